// File: rtl/operand_bank_pkg.sv
// Shared instruction-side types and widths used by proc and the operand bank.
package operand_bank_pkg;

  localparam int VALUE_WIDTH = 8;
  localparam int MEM_WIDTH   = 5;

  typedef enum logic [1:0] {
    CH_REG = 2'b00,
    CH_MEM = 2'b01,
    CH_IMM = 2'b10,
    CH_IO  = 2'b11
  } choice_t;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD1,
    RD2,
    RESP
  } state_t;

endpackage

// File: rtl/operand_spram.sv
// Single-port data RAM: one write enable, registered (one-cycle) read.
module operand_spram #(
  parameter int VALUE_WIDTH = operand_bank_pkg::VALUE_WIDTH,
  parameter int MEM_WIDTH   = operand_bank_pkg::MEM_WIDTH
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [MEM_WIDTH-1:0]   addr,
  input  logic [VALUE_WIDTH-1:0] wdata,
  output logic [VALUE_WIDTH-1:0] rdata
);

  logic [VALUE_WIDTH-1:0] mem [2**MEM_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/operand_bank.sv
// Operand-side responder: serves two source-operand reads and one writeback
// from a register file, a data RAM, an immediate field or the IO port.
//
// state | meaning
// INIT  | sweep RAM to zero, readies low
// IDLE  | accept writeback (priority) or read request
// RD1   | capture first MEM operand from RAM
// RD2   | capture src2 MEM operand from RAM
// RESP  | hold rsp_valid and data until rsp_ready
module operand_bank #(
  parameter int VALUE_WIDTH = operand_bank_pkg::VALUE_WIDTH,
  parameter int MEM_WIDTH   = operand_bank_pkg::MEM_WIDTH,
  parameter int REG_COUNT   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [MEM_WIDTH-1:0]   src1_addr,
  input  logic [1:0]             src1_choice,
  input  logic [MEM_WIDTH-1:0]   src2_addr,
  input  logic [1:0]             src2_choice,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [VALUE_WIDTH-1:0] src1_data,
  output logic [VALUE_WIDTH-1:0] src2_data,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic [MEM_WIDTH-1:0]   wb_addr,
  input  logic [1:0]             wb_choice,
  input  logic [VALUE_WIDTH-1:0] wb_data,
  input  logic [VALUE_WIDTH-1:0] io_in,
  output logic [VALUE_WIDTH-1:0] io_out,
  output logic                   wb_err,
  output logic                   init_done
);
  import operand_bank_pkg::*;

  localparam int RIDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  state_t                 state, state_nxt;
  logic [MEM_WIDTH-1:0]   cnt;
  logic [VALUE_WIDTH-1:0] rf [REG_COUNT];
  choice_t                c1_q, c2_q;
  logic [MEM_WIDTH-1:0]   a2_q;
  logic                   ram_we;
  logic [MEM_WIDTH-1:0]   ram_addr;
  logic [VALUE_WIDTH-1:0] ram_wdata, ram_rdata;
  logic                   in1_mem, in2_mem, wb_fire, req_fire;

  assign in1_mem  = (choice_t'(src1_choice) == CH_MEM);
  assign in2_mem  = (choice_t'(src2_choice) == CH_MEM);
  assign wb_fire  = wb_valid & wb_ready;
  assign req_fire = req_valid & req_ready;

  function automatic logic reg_hit(input logic [MEM_WIDTH-1:0] a);
    return int'(a) < REG_COUNT;
  endfunction

  function automatic logic [VALUE_WIDTH-1:0] resolve(input choice_t ch,
                                                     input logic [MEM_WIDTH-1:0] a);
    logic [VALUE_WIDTH-1:0] r;
    case (ch)
      CH_REG:  r = reg_hit(a) ? rf[a[RIDX_W-1:0]] : '0;
      CH_IMM:  r = VALUE_WIDTH'(a);
      CH_IO:   r = io_in;
      default: r = '0;
    endcase
    return r;
  endfunction

  operand_spram #(.VALUE_WIDTH(VALUE_WIDTH), .MEM_WIDTH(MEM_WIDTH)) u_spram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  // RAM reads are launched one state early so the registered read data is
  // ready to capture at the end of RD1/RD2.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    wb_ready  = 1'b0;
    rsp_valid = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = a2_q;
    ram_wdata = wb_data;
    case (state)
      INIT: begin
        ram_we    = 1'b1;
        ram_addr  = cnt;
        ram_wdata = '0;
        if (&cnt) state_nxt = IDLE;
      end
      IDLE: begin
        wb_ready  = 1'b1;
        req_ready = !wb_valid;
        if (wb_valid) begin
          ram_addr = wb_addr;
          ram_we   = (choice_t'(wb_choice) == CH_MEM);
        end else begin
          ram_addr = in1_mem ? src1_addr : src2_addr;
          if (req_valid) state_nxt = (in1_mem || in2_mem) ? RD1 : RESP;
        end
      end
      RD1: state_nxt = (c1_q == CH_MEM && c2_q == CH_MEM) ? RD2 : RESP;
      RD2: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      init_done <= 1'b0;
      io_out    <= '0;
      wb_err    <= 1'b0;
      src1_data <= '0;
      src2_data <= '0;
      c1_q      <= CH_REG;
      c2_q      <= CH_REG;
      a2_q      <= '0;
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
    end else begin
      if (state == INIT) begin
        cnt <= cnt + 1'b1;
        if (&cnt) init_done <= 1'b1;
      end
      if (wb_fire) begin
        case (choice_t'(wb_choice))
          CH_REG: begin
            if (reg_hit(wb_addr)) rf[wb_addr[RIDX_W-1:0]] <= wb_data;
            else                  wb_err <= 1'b1;
          end
          CH_IO:   io_out <= wb_data;
          CH_IMM:  wb_err <= 1'b1;
          default: ;
        endcase
      end
      if (req_fire) begin
        c1_q <= choice_t'(src1_choice);
        c2_q <= choice_t'(src2_choice);
        a2_q <= src2_addr;
        if (!in1_mem) src1_data <= resolve(choice_t'(src1_choice), src1_addr);
        if (!in2_mem) src2_data <= resolve(choice_t'(src2_choice), src2_addr);
      end
      if (state == RD1) begin
        if (c1_q == CH_MEM) src1_data <= ram_rdata;
        else                src2_data <= ram_rdata;
      end
      if (state == RD2) src2_data <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_operand_bank.sv
// Self-checking bench for operand_bank: reference model plus response scoreboard.
module tb_operand_bank;

  typedef struct {
    logic [7:0] s1;
    logic [7:0] s2;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4:0] src1_addr, src2_addr, wb_addr;
  logic [1:0] src1_choice, src2_choice, wb_choice;
  logic [7:0] src1_data, src2_data, wb_data, io_in, io_out;
  logic       wb_valid, wb_ready, wb_err, init_done;

  int checks = 0;
  int errors = 0;

  exp_t       sb[$];
  logic [7:0] m_reg [8];
  logic [7:0] m_mem [32];
  logic [7:0] m_io;
  logic       m_err;

  operand_bank dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .src1_addr(src1_addr), .src1_choice(src1_choice),
    .src2_addr(src2_addr), .src2_choice(src2_choice),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .src1_data(src1_data), .src2_data(src2_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_choice(wb_choice), .wb_data(wb_data),
    .io_in(io_in), .io_out(io_out), .wb_err(wb_err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    m_io  = 8'h00;
    m_err = 1'b0;
  endtask

  function automatic logic [7:0] model_rd(input logic [1:0] ch, input logic [4:0] a);
    case (ch)
      2'b00:   return (a < 5'd8) ? m_reg[a[2:0]] : 8'h00;
      2'b01:   return m_mem[a];
      2'b10:   return {3'b000, a};
      default: return io_in;
    endcase
  endfunction

  // Counts rising edges after rst release until init_done; readies must stay low.
  task automatic wait_init(input string name);
    int n = 0;
    int bad = 0;
    while (!init_done && n < 100) begin
      tick();
      n++;
      if (!init_done && (req_ready || wb_ready || rsp_valid)) bad++;
    end
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL %s init_cycles: got %0d want 32", name, n);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s ready_during_init: %0d cycles with a ready/valid high, want 0", name, bad);
    end
  endtask

  task automatic do_wb(input logic [1:0] ch, input logic [4:0] a, input logic [7:0] d);
    int n = 0;
    wb_valid = 1'b1; wb_choice = ch; wb_addr = a; wb_data = d;
    #1;
    while (!wb_ready && n < 64) begin tick(); n++; end
    checks++;
    if (!wb_ready) begin
      errors++;
      $display("FAIL wb_accept_timeout: wb_ready=%b want 1", wb_ready);
      wb_valid = 1'b0;
      return;
    end
    tick();
    wb_valid = 1'b0;
    case (ch)
      2'b00: if (a < 5'd8) m_reg[a[2:0]] = d; else m_err = 1'b1;
      2'b01: m_mem[a] = d;
      2'b10: m_err = 1'b1;
      default: m_io = d;
    endcase
    checks++;
    if (io_out !== m_io || wb_err !== m_err) begin
      errors++;
      $display("FAIL wb_side_effects: io_out=%h wb_err=%b want io_out=%h wb_err=%b",
               io_out, wb_err, m_io, m_err);
    end
  endtask

  // Completes a request already driven on the req_* inputs; optionally stalls rsp_ready.
  task automatic finish_req(input string name, input int hold);
    exp_t e, got;
    int n = 0;
    int bad = 0;
    logic [7:0] h1, h2;
    #1;
    while (!req_ready && n < 64) begin tick(); n++; end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL %s req_accept_timeout: req_ready=%b want 1", name, req_ready);
      req_valid = 1'b0;
      return;
    end
    e.s1  = model_rd(src1_choice, src1_addr);
    e.s2  = model_rd(src2_choice, src2_addr);
    e.lat = 1 + int'(src1_choice == 2'b01) + int'(src2_choice == 2'b01);
    sb.push_back(e);
    tick();
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    got = sb.pop_front();
    checks++;
    if (!rsp_valid || n !== got.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d (rsp_valid=%b) want %0d", name, n, rsp_valid, got.lat);
    end
    checks++;
    if (src1_data !== got.s1) begin
      errors++;
      $display("FAIL %s src1_data: got %h want %h", name, src1_data, got.s1);
    end
    checks++;
    if (src2_data !== got.s2) begin
      errors++;
      $display("FAIL %s src2_data: got %h want %h", name, src2_data, got.s2);
    end
    h1 = src1_data;
    h2 = src2_data;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; src1_choice = 2'b10; src1_addr = 5'd1;
      io_in = io_in + 8'h11;
      tick();
      if (!rsp_valid || req_ready || src1_data !== h1 || src2_data !== h2) bad++;
    end
    if (hold > 0) begin
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL %s stall_hold: %0d unstable/accepting cycles, want 0", name, bad);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s rsp_release: rsp_valid=%b want 0", name, rsp_valid);
    end
  endtask

  task automatic do_req(input string name, input logic [1:0] c1, input logic [4:0] a1,
                        input logic [1:0] c2, input logic [4:0] a2, input int hold);
    req_valid = 1'b1; src1_choice = c1; src1_addr = a1; src2_choice = c2; src2_addr = a2;
    finish_req(name, hold);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({req_ready, wb_ready, rsp_valid, wb_err, init_done} !== 5'b0 ||
        src1_data !== 8'h00 || src2_data !== 8'h00 || io_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: rdy=%b wbr=%b rv=%b err=%b done=%b s1=%h s2=%h io=%h want all 0",
               req_ready, wb_ready, rsp_valid, wb_err, init_done, src1_data, src2_data, io_out);
    end
    rst = 1'b0;
    model_reset();
    wait_init("reset");
  endtask

  task automatic test_mem_cleared();
    do_req("mem_clear_0_31", 2'b01, 5'd0, 2'b01, 5'd31, 0);
    do_req("mem_clear_5", 2'b01, 5'd5, 2'b10, 5'd0, 0);
  endtask

  task automatic test_reg_imm();
    do_wb(2'b00, 5'd3, 8'hA5);
    do_req("reg3_imm17", 2'b00, 5'd3, 2'b10, 5'd17, 0);
    do_req("reg_oob_imm31", 2'b00, 5'd12, 2'b10, 5'd31, 0);
  endtask

  task automatic test_mem_reads();
    do_wb(2'b01, 5'd7, 8'h3C);
    do_wb(2'b01, 5'd9, 8'h81);
    do_req("mem7_mem9", 2'b01, 5'd7, 2'b01, 5'd9, 0);
    do_req("imm4_mem7", 2'b10, 5'd4, 2'b01, 5'd7, 0);
    do_req("mem9_reg3", 2'b01, 5'd9, 2'b00, 5'd3, 0);
    io_in = 8'h6E;
    do_req("io_mem31", 2'b11, 5'd0, 2'b01, 5'd31, 0);
  endtask

  task automatic test_priority();
    wb_valid = 1'b1; wb_choice = 2'b01; wb_addr = 5'd2; wb_data = 8'h55;
    req_valid = 1'b1; src1_choice = 2'b01; src1_addr = 5'd2; src2_choice = 2'b10; src2_addr = 5'd9;
    #1;
    checks++;
    if (req_ready !== 1'b0 || wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL priority_readies: req_ready=%b wb_ready=%b want 0/1", req_ready, wb_ready);
    end
    tick();
    wb_valid = 1'b0;
    m_mem[2] = 8'h55;
    finish_req("priority_mem2", 0);
  endtask

  task automatic test_back_pressure();
    io_in = 8'hC3;
    do_req("stall_reg3_io", 2'b00, 5'd3, 2'b11, 5'd0, 4);
    do_req("stall_mem7_mem2", 2'b01, 5'd7, 2'b01, 5'd2, 4);
  endtask

  task automatic test_err_io();
    do_wb(2'b00, 5'd12, 8'hEE);
    do_req("reg4_after_oob_wb", 2'b00, 5'd4, 2'b00, 5'd3, 0);
    do_wb(2'b11, 5'd0, 8'h0F);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int seen = 0;
    req_valid = 1'b1; src1_choice = 2'b01; src1_addr = 5'd7; src2_choice = 2'b01; src2_addr = 5'd9;
    #1;
    while (!req_ready && n < 64) begin tick(); n++; end
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || io_out !== 8'h00 || init_done !== 1'b0 || wb_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_values: rsp_valid=%b io_out=%h init_done=%b wb_err=%b want 0",
               rsp_valid, io_out, init_done, wb_err);
    end
    rst = 1'b0;
    model_reset();
    rsp_ready = 1'b1;
    fork
      wait_init("reset_mid");
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (rsp_valid) seen++;
      end
    join
    rsp_ready = 1'b0;
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_rsp: rsp_valid high %0d cycles, want 0", seen);
    end
    do_req("reset_mid_mem7_cleared", 2'b01, 5'd7, 2'b00, 5'd3, 0);
    do_wb(2'b10, 5'd1, 8'h12);
    do_wb(2'b00, 5'd1, 8'h34);
    do_req("reg1_after_err", 2'b00, 5'd1, 2'b10, 5'd0, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; rsp_ready = 1'b0; wb_valid = 1'b0;
    src1_addr = '0; src2_addr = '0; wb_addr = '0;
    src1_choice = '0; src2_choice = '0; wb_choice = '0;
    wb_data = '0; io_in = 8'h00;
    model_reset();
    test_reset();
    test_mem_cleared();
    test_reg_imm();
    test_mem_reads();
    test_priority();
    test_back_pressure();
    test_err_io();
    test_reset_mid();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_bank.md
Name: operand_bank

Overview:
Operand-side responder for the processor core. It serves the core's two source-operand read requests (source1/source2 address plus choice) and its destination writeback (dest address plus choice).
- Source values come from a register file, a single-port data RAM, an immediate field or the input port.
- Data RAM reads are serialized through a small FSM with valid/ready handshakes.
- The block sits between the proc decode/ALU stages and storage/IO.

Parameters:
VALUE_WIDTH, 8, operand/data word width (matches core alu_out)
MEM_WIDTH, 5, operand address width; data RAM depth = 2**MEM_WIDTH; must be <= VALUE_WIDTH
REG_COUNT, 8, register file entries, indexed by addr[$clog2(REG_COUNT)-1:0]

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  operand read request valid
req_ready  out  1  block can accept a read request
src1_addr  in  MEM_WIDTH  source1 address/immediate field
src1_choice  in  2  source1 selector
src2_addr  in  MEM_WIDTH  source2 address/immediate field
src2_choice  in  2  source2 selector
rsp_valid  out  1  src1_data/src2_data valid
rsp_ready  in  1  core consumes the response
src1_data  out  VALUE_WIDTH  source1 value
src2_data  out  VALUE_WIDTH  source2 value
wb_valid  in  1  writeback valid
wb_ready  out  1  block can accept a writeback
wb_addr  in  MEM_WIDTH  destination address
wb_choice  in  2  destination selector
wb_data  in  VALUE_WIDTH  value to write (alu_out)
io_in  in  VALUE_WIDTH  external input port
io_out  out  VALUE_WIDTH  registered output port
wb_err  out  1  sticky illegal-writeback flag
init_done  out  1  RAM clear complete

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Choice encoding:
  - CH_REG=2'b00: register file.
  - CH_MEM=2'b01: data RAM.
  - CH_IMM=2'b10: value is the address field, zero-extended.
  - CH_IO=2'b11: read returns io_in; write sets io_out; the address is ignored.
- Reset values: req_ready=0, wb_ready=0, rsp_valid=0, src1_data=0, src2_data=0, io_out=0, wb_err=0, init_done=0. All registers clear to 0. FSM enters INIT with the sweep counter at 0.
- FSM states: INIT, IDLE, RD1, RD2, RESP.
- INIT:
  - Writes 0 to RAM address cnt, incrementing each cycle.
  - After writing address 2**MEM_WIDTH-1, goes to IDLE and sets init_done=1 (takes 32 cycles at the default).
  - Both readies are low throughout.
- IDLE:
  - wb_ready=1.
  - req_ready = !wb_valid, so writeback has priority and a simultaneous request waits.
- Writeback accept (wb_valid & wb_ready, takes effect at that edge):
  - REG: write register; an index >= REG_COUNT is dropped and sets wb_err.
  - MEM: RAM write.
  - IO: io_out <= wb_data.
  - IMM: dropped and sets wb_err.
  - State stays IDLE.
- Request accept (req_valid & req_ready):
  - Latches both choices and addresses.
  - REG, IMM and IO operands are resolved at the accept edge; io_in is sampled at that edge.
  - REG read with index >= REG_COUNT returns 0 (no error).
  - Next state depends on the number of MEM operands:
    - 0 MEM operands: RESP.
    - 1 or 2 MEM operands: RD1.
- RD1: the RAM reads the first MEM operand (src1 if MEM, else src2); its data is captured at the end of RD1. Next state is RD2 if both operands are MEM, else RESP.
- RD2: reads and captures src2. Next state RESP.
- RAM read is synchronous, one cycle.
- Latency, counted from the accept edge to rsp_valid high: 1 cycle with no MEM operands, 2 with one, 3 with two.
- RESP: rsp_valid=1 and the data is held stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE and drop rsp_valid at that edge.
- req_ready and wb_ready are both 0 in RD1, RD2 and RESP, so there is no read/write overlap and no hazard. A read issued after a writeback sees the new value.
- Reset mid-operation: a pending response is discarded, rsp_valid falls at the reset edge, io_out clears, the RAM clear restarts, and init_done drops.

Decomposition:
- Extend the shared instructions package with:
  - the choice typedef (CH_REG/CH_MEM/CH_IMM/CH_IO);
  - the state enum;
  - the VALUE_WIDTH and MEM_WIDTH constants already used by proc.
- One sub-module: operand_spram. It is a single-port RAM with synchronous read, one write enable, 2**MEM_WIDTH x VALUE_WIDTH. The FSM muxes its address between cnt, wb_addr and the latched source address.

Test Plan:
- Reset, then idle → init_done rises exactly 32 cycles after rst falls; readies are 0 until then; every MEM read returns 0.
- wb REG addr 3 data 8'hA5, then request src1 REG3, src2 IMM 5'd17 → 1-cycle latency; src1=8'hA5, src2=8'd17.
- wb MEM 7=8'h3C and MEM 9=8'h81, then request src1 MEM7, src2 MEM9 → rsp_valid 3 cycles after accept; 8'h3C and 8'h81.
- Same cycle: wb_valid (MEM 2=8'h55) and req_valid (src1 MEM2) → wb accepted first with req_ready=0; the request is accepted the next cycle and returns 8'h55.
- rsp_ready held 0 for 4 cycles → data stable and rsp_valid high; new requests are not accepted; the response is released on the rsp_ready edge.
- Error, IO and reset cases:
  - wb IMM → wb_err=1 and stays set.
  - wb IO 8'h0F → io_out=8'h0F.
  - rst asserted in RD1 → rsp_valid never asserts; io_out=0; INIT restarts.
